// File: rtl/iic_pkg.sv
// -----------------------------------------------------------------------------
// iic_pkg
// Shared definitions for the two-wire configuration bus blocks (target register
// file and the bus synchroniser shared with the initiator side).
//   - iic_state_e : target protocol states
//   - iic_bus_t   : synchronised bus events handed from iic_bus_sync to a user
//   - ACK / NACK and R/W bit encodings, default DAC target address
// -----------------------------------------------------------------------------
package iic_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_ACK
  } iic_state_e;

  // One-cycle event pulses plus the SDA level aligned with them.
  typedef struct packed {
    logic sda;       // SDA level, valid together with scl_rise
    logic scl_rise;
    logic scl_fall;
    logic start;     // SDA fell while SCL high
    logic stop;      // SDA rose while SCL high
  } iic_bus_t;

  localparam logic IIC_ACK      = 1'b0;
  localparam logic IIC_NACK     = 1'b1;
  localparam logic IIC_RW_WRITE = 1'b0;
  localparam logic IIC_RW_READ  = 1'b1;

  localparam logic [6:0] IIC_DAC_ADDR = 7'h76;

endpackage

// File: rtl/iic_bus_sync.sv
// -----------------------------------------------------------------------------
// iic_bus_sync
// Brings SCL/SDA into the i_clk domain and turns them into event pulses.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_scl, i_sda   : raw bus lines, asynchronous to i_clk
//   o_bus          : registered scl_rise / scl_fall / start / stop pulses and
//                    the SDA level aligned with them
// Each line passes a 2-flop synchroniser. With IIC_GLITCH_FILTER_EN defined, a
// line additionally has to hold a new value for FILTER_CYCLES consecutive
// samples before it is accepted (latency 3 + FILTER_CYCLES instead of 3).
// -----------------------------------------------------------------------------
module iic_bus_sync
  import iic_pkg::*;
#(
  parameter int FILTER_CYCLES = 4
) (
  input  logic     i_clk,
  input  logic     i_rst_n,
  input  logic     i_scl,
  input  logic     i_sda,
  output iic_bus_t o_bus
);

  // Index 0 = SCL, index 1 = SDA throughout.
  logic [1:0] r_meta;
  logic [1:0] r_sync;
  logic [1:0] w_line;
  logic [1:0] r_prev;
  iic_bus_t   r_bus;

  // Reset to the idle bus level (both lines high) so leaving reset on an idle
  // bus produces no spurious edges.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others; blocking here would collapse the
  // synchroniser into a single stage.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= 2'b11;
      r_sync <= 2'b11;
    end else begin
      r_meta <= {i_sda, i_scl};
      r_sync <= r_meta;
    end
  end

`ifdef IIC_GLITCH_FILTER_EN
  logic [1:0]      r_filt;
  logic [1:0][3:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_filt <= 2'b11;
      r_cnt  <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (r_sync[i] == r_filt[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == 4'(FILTER_CYCLES - 1)) begin
          r_filt[i] <= r_sync[i];
          r_cnt[i]  <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 4'd1;
        end
      end
    end
  end

  assign w_line = r_filt;
`else
  assign w_line = r_sync;
`endif

  // The counter is 4 bits wide; a depth outside 1..15 is a configuration error.
  a_filter_range : assert property (@(posedge i_clk)
    (FILTER_CYCLES >= 1) && (FILTER_CYCLES <= 15));

  // START/STOP require SCL high both before and after the SDA change, so an
  // SDA transition racing an SCL edge is never mistaken for a bus condition.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_prev <= 2'b11;
      r_bus  <= '{sda: 1'b1, default: 1'b0};
    end else begin
      r_prev         <= w_line;
      r_bus.sda      <= w_line[1];
      r_bus.scl_rise <=  w_line[0] & ~r_prev[0];
      r_bus.scl_fall <= ~w_line[0] &  r_prev[0];
      r_bus.start    <=  w_line[0] &  r_prev[0] &  r_prev[1] & ~w_line[1];
      r_bus.stop     <=  w_line[0] &  r_prev[0] & ~r_prev[1] &  w_line[1];
    end
  end

  assign o_bus = r_bus;

endmodule

// File: rtl/iic_target_regfile.sv
// -----------------------------------------------------------------------------
// iic_target_regfile
// Two-wire bus target with a 256 x 8 register file and an auto-incrementing
// 8-bit register pointer. Accepted register writes are mirrored to fabric as a
// one-cycle strobe; fabric can read any entry combinationally.
//   Clk, Reset_n    : system clock (>= 8x SCL), asynchronous active-low reset
//   SCL_in, SDA_in  : bus lines, asynchronous to Clk
//   SDA_oe          : 1 = pull SDA low (open drain), 0 = release
//   Wr_stb/addr/data: one pulse per accepted data byte
//   Rd_addr/Rd_data : fabric readback port, Rd_data = regfile[Rd_addr]
//   Busy            : high from START until STOP
// Optional: IIC_GLITCH_FILTER_EN enables the FILTER_CYCLES-deep line filter
// inside iic_bus_sync.
// -----------------------------------------------------------------------------
module iic_target_regfile
  import iic_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR    = IIC_DAC_ADDR,
  parameter int         FILTER_CYCLES = 4
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       SCL_in,
  input  logic       SDA_in,
  output logic       SDA_oe,
  output logic       Wr_stb,
  output logic [7:0] Wr_addr,
  output logic [7:0] Wr_data,
  input  logic [7:0] Rd_addr,
  output logic [7:0] Rd_data,
  output logic       Busy
);

  iic_bus_t   w_bus;

  iic_state_e r_state;
  logic [3:0] r_bit_cnt;
  logic [7:0] r_shift;
  logic [7:0] r_ptr;
  logic       r_rw;
  logic       r_mack;
  logic       r_wr_pend;
  logic       r_sda_oe;
  logic       r_busy;
  logic       r_wr_stb;
  logic [7:0] r_wr_addr;
  logic [7:0] r_wr_data;
  logic [7:0] r_regfile [256];

  logic [7:0] w_rd_byte;
  logic       w_rx_bit;
  logic       w_rx_done;
  logic       w_ack_fall;

  iic_bus_sync #(
    .FILTER_CYCLES(FILTER_CYCLES)
  ) u_bus_sync (
    .i_clk  (Clk),
    .i_rst_n(Reset_n),
    .i_scl  (SCL_in),
    .i_sda  (SDA_in),
    .o_bus  (w_bus)
  );

  assign w_rd_byte  = r_regfile[r_ptr];
  assign w_rx_bit   = w_bus.scl_rise && (r_bit_cnt < 4'd8);
  assign w_rx_done  = w_bus.scl_fall && (r_bit_cnt == 4'd8);
  // ACK states set the counter to 1 on the ACK clock's rising edge, so the
  // falling edge that entered the state is not mistaken for the end of the slot.
  assign w_ack_fall = w_bus.scl_fall && (r_bit_cnt == 4'd1);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state   <= ST_IDLE;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_ptr     <= '0;
      r_rw      <= IIC_RW_WRITE;
      r_mack    <= IIC_NACK;
      r_wr_pend <= 1'b0;
      r_sda_oe  <= 1'b0;
      r_busy    <= 1'b0;
      r_wr_stb  <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_wr_stb <= 1'b0;

      // Data byte was ACKed on the previous cycle: strobe it to fabric and
      // advance the pointer (wraps 0xFF -> 0x00 naturally).
      if (r_wr_pend) begin
        r_wr_pend <= 1'b0;
        r_wr_stb  <= 1'b1;
        r_wr_addr <= r_ptr;
        r_wr_data <= r_shift;
        r_ptr     <= r_ptr + 8'd1;
      end

      if (w_bus.stop) begin
        r_state   <= ST_IDLE;
        r_sda_oe  <= 1'b0;
        r_busy    <= 1'b0;
        r_bit_cnt <= '0;
      end else if (w_bus.start) begin
        r_state   <= ST_ADDR;
        r_sda_oe  <= 1'b0;
        r_busy    <= 1'b1;
        r_bit_cnt <= '0;
      end else begin
        case (r_state)
          ST_IDLE: ;

          ST_ADDR: begin
            if (w_rx_bit) begin
              r_shift   <= {r_shift[6:0], w_bus.sda};
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end else if (w_rx_done) begin
              r_bit_cnt <= '0;
              if (r_shift[7:1] == SLAVE_ADDR) begin
                r_sda_oe <= 1'b1;
                r_rw     <= r_shift[0];
                r_state  <= ST_ADDR_ACK;
              end else begin
                r_state  <= ST_IDLE;
              end
            end
          end

          ST_ADDR_ACK: begin
            if (w_bus.scl_rise) begin
              r_bit_cnt <= 4'd1;
            end else if (w_ack_fall) begin
              r_bit_cnt <= '0;
              if (r_rw == IIC_RW_READ) begin
                r_shift  <= w_rd_byte;
                r_sda_oe <= ~w_rd_byte[7];
                r_state  <= ST_RDATA;
              end else begin
                r_sda_oe <= 1'b0;
                r_state  <= ST_PTR;
              end
            end
          end

          ST_PTR: begin
            if (w_rx_bit) begin
              r_shift   <= {r_shift[6:0], w_bus.sda};
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end else if (w_rx_done) begin
              r_bit_cnt <= '0;
              r_ptr     <= r_shift;
              r_sda_oe  <= 1'b1;
              r_state   <= ST_PTR_ACK;
            end
          end

          ST_PTR_ACK, ST_WDATA_ACK: begin
            if (w_bus.scl_rise) begin
              r_bit_cnt <= 4'd1;
            end else if (w_ack_fall) begin
              r_bit_cnt <= '0;
              r_sda_oe  <= 1'b0;
              r_state   <= ST_WDATA;
            end
          end

          ST_WDATA: begin
            if (w_rx_bit) begin
              r_shift   <= {r_shift[6:0], w_bus.sda};
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end else if (w_rx_done) begin
              r_bit_cnt <= '0;
              r_sda_oe  <= 1'b1;
              r_wr_pend <= 1'b1;
              r_state   <= ST_WDATA_ACK;
            end
          end

          // The MSB is already on the bus when this state is entered; each
          // rising edge moves the next bit into r_shift[7] for the next fall.
          ST_RDATA: begin
            if (w_rx_bit) begin
              r_shift   <= {r_shift[6:0], 1'b0};
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end else if (w_rx_done) begin
              r_bit_cnt <= '0;
              r_sda_oe  <= 1'b0;
              r_state   <= ST_RDATA_ACK;
            end else if (w_bus.scl_fall) begin
              r_sda_oe  <= ~r_shift[7];
            end
          end

          ST_RDATA_ACK: begin
            if (w_bus.scl_rise) begin
              r_mack    <= w_bus.sda;
              r_ptr     <= r_ptr + 8'd1;
              r_bit_cnt <= 4'd1;
            end else if (w_ack_fall) begin
              r_bit_cnt <= '0;
              if (r_mack == IIC_ACK) begin
                r_shift  <= w_rd_byte;
                r_sda_oe <= ~w_rd_byte[7];
                r_state  <= ST_RDATA;
              end else begin
                r_state  <= ST_IDLE;
              end
            end
          end

          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  // Written one cycle after the strobe, so a fabric read of the same entry
  // sees the old value during the strobe and the new one on the next cycle.
  // NOTE: the register file deliberately has no reset; contents survive
  // Reset_n and this keeps it mappable onto plain RAM.
  always_ff @(posedge Clk) begin
    if (r_wr_stb) begin
      r_regfile[r_wr_addr] <= r_wr_data;
    end
  end

  assign Rd_data = r_regfile[Rd_addr];
  assign SDA_oe  = r_sda_oe;
  assign Wr_stb  = r_wr_stb;
  assign Wr_addr = r_wr_addr;
  assign Wr_data = r_wr_data;
  assign Busy    = r_busy;

endmodule

// File: tb/tb_iic_target_regfile.sv
// -----------------------------------------------------------------------------
// tb_iic_target_regfile
// Directed bench: a bus-functional master drives SCL/SDA (SDA wired-AND with
// the target's open-drain pull-down) and checks ACKs, read data, strobes,
// register contents, Busy and reset behaviour against hand-computed values.
// -----------------------------------------------------------------------------
module tb_iic_target_regfile;

  localparam int Q = 12;  // Clk cycles per quarter SCL period

  logic       Clk = 1'b0;
  logic       Reset_n;
  logic       m_scl;
  logic       m_sda;
  logic       sda_bus;
  logic       SDA_oe;
  logic       Wr_stb;
  logic [7:0] Wr_addr;
  logic [7:0] Wr_data;
  logic [7:0] Rd_addr;
  logic [7:0] Rd_data;
  logic       Busy;

  int n_checks = 0;
  int n_fail   = 0;

  int         stb_cnt  = 0;
  int         oe_cnt   = 0;
  int         busy_cnt = 0;
  logic [7:0] last_wa  = '0;
  logic [7:0] last_wd  = '0;

  assign sda_bus = m_sda & ~SDA_oe;

  always #5 Clk = ~Clk;

  iic_target_regfile #(
    .SLAVE_ADDR   (7'h76),
    .FILTER_CYCLES(4)
  ) dut (
    .Clk    (Clk),
    .Reset_n(Reset_n),
    .SCL_in (m_scl),
    .SDA_in (sda_bus),
    .SDA_oe (SDA_oe),
    .Wr_stb (Wr_stb),
    .Wr_addr(Wr_addr),
    .Wr_data(Wr_data),
    .Rd_addr(Rd_addr),
    .Rd_data(Rd_data),
    .Busy   (Busy)
  );

  always @(negedge Clk) begin
    if (Wr_stb) begin
      stb_cnt++;
      last_wa = Wr_addr;
      last_wd = Wr_data;
    end
    if (SDA_oe) oe_cnt++;
    if (Busy)   busy_cnt++;
  end

  initial begin
    repeat (60000) @(posedge Clk);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation time limit reached");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_q();
    repeat (Q) @(negedge Clk);
  endtask

  task automatic bus_start();
    m_sda = 1'b1; wait_q();
    m_scl = 1'b1; wait_q();
    m_sda = 1'b0; wait_q();
    m_scl = 1'b0; wait_q();
  endtask

  task automatic bus_stop();
    m_sda = 1'b0; wait_q();
    m_scl = 1'b1; wait_q();
    m_sda = 1'b1; wait_q();
  endtask

  task automatic send_bit(input logic b);
    m_sda = b;    wait_q();
    m_scl = 1'b1; wait_q();
    m_scl = 1'b0; wait_q();
  endtask

  task automatic recv_bit(output logic b);
    m_sda = 1'b1; wait_q();
    m_scl = 1'b1;
    repeat (Q / 2) @(negedge Clk);
    b = sda_bus;
    repeat (Q - Q / 2) @(negedge Clk);
    m_scl = 1'b0; wait_q();
  endtask

  task automatic send_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    recv_bit(ack);
  endtask

  task automatic recv_byte(output logic [7:0] d, input logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(b);
      d[i] = b;
    end
    send_bit(ack);
  endtask

  task automatic read_reg(input logic [7:0] a, input string tag, input logic [7:0] exp);
    Rd_addr = a;
    @(negedge Clk);
    check(tag, Rd_data, exp);
  endtask

  initial begin
    logic       ack;
    logic [7:0] d0;
    logic [7:0] d1;
    int         s0;
    int         o0;
    int         b0;

    m_scl   = 1'b1;
    m_sda   = 1'b1;
    Rd_addr = '0;
    Reset_n = 1'b0;
    repeat (4) @(negedge Clk);
    check("rst_sda_oe",  SDA_oe,  1'b0);
    check("rst_wr_stb",  Wr_stb,  1'b0);
    check("rst_wr_addr", Wr_addr, 8'h00);
    check("rst_wr_data", Wr_data, 8'h00);
    check("rst_busy",    Busy,    1'b0);
    Reset_n = 1'b1;
    wait_q();

    // Single write: 0x76/W, ptr 0x49, data 0xC0.
    s0 = stb_cnt;
    bus_start();
    send_byte(8'hEC, ack); check("t1_addr_ack", ack, 1'b0);
    check("t1_busy", Busy, 1'b1);
    send_byte(8'h49, ack); check("t1_ptr_ack", ack, 1'b0);
    send_byte(8'hC0, ack); check("t1_data_ack", ack, 1'b0);
    bus_stop();
    check("t1_busy_after_stop", Busy, 1'b0);
    check("t1_stb_count", stb_cnt - s0, 1);
    check("t1_wr_addr", last_wa, 8'h49);
    check("t1_wr_data", last_wd, 8'hC0);
    read_reg(8'h49, "t1_reg49", 8'hC0);

    // Wrong address: target stays silent.
    s0 = stb_cnt;
    o0 = oe_cnt;
    bus_start();
    send_byte(8'hA0, ack); check("t2_addr_nack", ack, 1'b1);
    send_byte(8'h49, ack);
    send_byte(8'h12, ack);
    send_byte(8'h34, ack);
    bus_stop();
    check("t2_oe_never", oe_cnt - o0, 0);
    check("t2_no_stb", stb_cnt - s0, 0);
    read_reg(8'h49, "t2_reg49_kept", 8'hC0);

    // Burst write across the pointer wrap.
    s0 = stb_cnt;
    bus_start();
    send_byte(8'hEC, ack);
    send_byte(8'hFE, ack);
    send_byte(8'h11, ack); check("t3_d0_ack", ack, 1'b0);
    send_byte(8'h22, ack);
    send_byte(8'h33, ack); check("t3_d2_ack", ack, 1'b0);
    bus_stop();
    check("t3_stb_count", stb_cnt - s0, 3);
    check("t3_last_addr", last_wa, 8'h00);
    read_reg(8'hFE, "t3_regFE", 8'h11);
    read_reg(8'hFF, "t3_regFF", 8'h22);
    read_reg(8'h00, "t3_reg00", 8'h33);

    // Preload 0x21/0x22, then pointer write + repeated START read.
    bus_start();
    send_byte(8'hEC, ack);
    send_byte(8'h21, ack);
    send_byte(8'h09, ack);
    send_byte(8'h16, ack);
    bus_stop();
    bus_start();
    send_byte(8'hEC, ack);
    send_byte(8'h21, ack);
    bus_start();
    send_byte(8'hED, ack); check("t4_rd_addr_ack", ack, 1'b0);
    recv_byte(d0, 1'b0);
    recv_byte(d1, 1'b1);
    check("t4_sda_released", SDA_oe, 1'b0);
    bus_stop();
    check("t4_byte0", d0, 8'h09);
    check("t4_byte1", d1, 8'h16);
    check("t4_busy_after_stop", Busy, 1'b0);

    // Reset asserted while the target ACKs a data byte.
    bus_start();
    send_byte(8'hEC, ack);
    send_byte(8'h30, ack);
    for (int i = 7; i >= 0; i--) send_bit(d0[i] ^ 1'b0 | (8'h5A >> i) & 1'b1 ? (8'h5A >> i) & 1'b1 : 1'b0);
    m_sda = 1'b1; wait_q();
    m_scl = 1'b1;
    repeat (Q / 2) @(negedge Clk);
    check("t5_ack_driven", SDA_oe, 1'b1);
    s0 = stb_cnt;
    Reset_n = 1'b0;
    #1;
    check("t5_async_release", SDA_oe, 1'b0);
    check("t5_busy_cleared", Busy, 1'b0);
    repeat (3) @(negedge Clk);
    check("t5_no_stb_in_reset", Wr_stb, 1'b0);
    Reset_n = 1'b1;
    wait_q();
    check("t5_no_stb_after", stb_cnt - s0, 0);
    s0 = stb_cnt;
    bus_start();
    send_byte(8'hEC, ack); check("t5_re_addr_ack", ack, 1'b0);
    send_byte(8'h31, ack);
    send_byte(8'hA5, ack); check("t5_re_data_ack", ack, 1'b0);
    bus_stop();
    check("t5_re_stb", stb_cnt - s0, 1);
    read_reg(8'h31, "t5_reg31", 8'hA5);

    // Short and long SDA low pulses with SCL high.
    b0 = busy_cnt;
    m_sda = 1'b0;
    repeat (2) @(negedge Clk);
    m_sda = 1'b1;
    repeat (20) @(negedge Clk);
`ifdef IIC_GLITCH_FILTER_EN
    check("t6_short_pulse_no_start", busy_cnt != b0, 1'b0);
`else
    check("t6_short_pulse_start", busy_cnt != b0, 1'b1);
`endif
    b0 = busy_cnt;
    m_sda = 1'b0;
    repeat (6) @(negedge Clk);
    m_sda = 1'b1;
    repeat (20) @(negedge Clk);
    check("t6_long_pulse_start", busy_cnt != b0, 1'b1);
    check("t6_busy_after_pulse", Busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/iic_target_regfile.md
Name: iic_target_regfile

Overview:
- I2C target (responder) for the same two-wire configuration bus that our iic_init master drives.
- Responds at a 7-bit address with a 256 x 8 register file, 8-bit register pointer with auto-increment, and write and read transfers.
- Used as the bus-functional DAC model in system simulation.
- Also used as an on-chip configuration target reachable from an external I2C master.
- Every accepted register write is mirrored to fabric as a one-cycle strobe.

Parameters:
- SLAVE_ADDR, 7'h76: address this target ACKs.
- FILTER_CYCLES, 4: consecutive stable samples required by the optional glitch filter (range 1-15).

Ports:
- Clk  input  1  system clock; must be at least 8x the SCL rate.
- Reset_n  input  1  asynchronous active-low reset.
- SCL_in  input  1  bus SCL, asynchronous to Clk.
- SDA_in  input  1  bus SDA, asynchronous to Clk.
- SDA_oe  output  1  1 = pull SDA low (open-drain); 0 = release.
- Wr_stb  output  1  one-cycle pulse per accepted data byte.
- Wr_addr  output  8  register address of the write being strobed.
- Wr_data  output  8  data of the write being strobed.
- Rd_addr  input  8  fabric readback address.
- Rd_data  output  8  regfile[Rd_addr], combinational.
- Busy  output  1  high from START until STOP.

Behaviour:
- Reset: asynchronous and active-low. While Reset_n is low: SDA_oe=0, Wr_stb=0, Wr_addr=0, Wr_data=0, Busy=0, pointer=0, state=IDLE.
  - Regfile contents are not reset.
  - Reset asserted mid-transfer releases SDA within the same cycle (asynchronous).
- Synchronisation: SCL_in and SDA_in each pass through a 2-flop synchroniser.
  - Edges are computed from the synchronised values.
  - Detection latency: 3 Clk cycles from the pin change.
- Bus conditions:
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
  - Both are recognised in every state and take priority over bit processing in the same cycle.
- Sampling and driving: data bits are sampled on SCL rising edges, MSB first. SDA_oe changes only on SCL falling edges; START and STOP are the only exceptions.
- States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK.
  - IDLE -> ADDR on START. Busy=1. Bit counter cleared.
  - ADDR: shift 8 bits. On the falling edge after bit 8:
    - Address matches: SDA_oe=1, go to ADDR_ACK.
    - No match: go to IDLE with SDA_oe=0; ignore the bus until the next START.
  - ADDR_ACK: on the next falling edge, release SDA.
    - R/W=0 -> PTR.
    - R/W=1 -> RDATA. SDA_oe = ~regfile[ptr][7] is driven on that same falling edge.
  - PTR: 8 bits are loaded into the pointer. ACK as above -> PTR_ACK -> WDATA.
  - WDATA: 8 bits. On the falling edge after bit 8:
    - SDA_oe=1.
    - Next cycle: Wr_stb=1, Wr_addr=ptr, Wr_data=byte, regfile[ptr] written, ptr increments with wrap 8'hFF -> 8'h00.
    - Then go to WDATA_ACK, and back to WDATA on the next falling edge.
  - RDATA: drive ~bit on each falling edge. After bit 8, release SDA and go to RDATA_ACK.
  - RDATA_ACK: sample the master ACK on the rising edge. Pointer increments.
    - ACK (0): load the next byte and drive its MSB on the falling edge -> RDATA.
    - NACK (1): -> IDLE with SDA released.
- Repeated START (any state): SDA_oe=0, go to ADDR; the pointer is kept. This supports the pointer-write then repeated-start-read sequence.
- STOP (any state):
  - Go to IDLE. SDA_oe=0. Busy=0.
  - A partial byte is discarded with no Wr_stb.
  - The pointer is kept.
- Clock stretching: never performed; SCL is input only.
- Wr_stb and a fabric Rd_addr hit on the same entry in the same cycle: Rd_data returns the old value, and the new value the following cycle.

Optional Feature:
- Macro: IIC_GLITCH_FILTER_EN.
- Defined: after synchronisation, each line passes a filter. The filtered value changes only after FILTER_CYCLES consecutive identical samples that differ from the current value. Pulses shorter than that are suppressed, including START/STOP glitches. Detection latency becomes 3+FILTER_CYCLES Clk cycles.
- Undefined: synchronised values are used directly with no filter.

Decomposition:
- Shared package iic_pkg holds:
  - state enum typedef;
  - IIC_ACK=1'b0, IIC_NACK=1'b1;
  - IIC_RW_WRITE=1'b0, IIC_RW_READ=1'b1;
  - default DAC address 7'h76.
- Sub-module iic_bus_sync: synchroniser, optional glitch filter, and SCL rise/fall, START and STOP pulse generation. It is shared with a future iic_init rewrite.

Test Plan:
- Write 0x76/W, ptr 0x49, data 0xC0, STOP:
  - ACK on all 3 ACK slots;
  - exactly one Wr_stb with Wr_addr=0x49, Wr_data=0xC0;
  - Rd_addr=0x49 gives Rd_data=0xC0;
  - Busy falls after STOP.
- Address 0x50/W then 3 bytes: SDA_oe stays 0 throughout; no Wr_stb; the previously written regfile entry is unchanged.
- Burst write ptr 0xFE, data 0x11, 0x22, 0x33: regs 0xFE=0x11, 0xFF=0x22, 0x00=0x33; three strobes.
- Preload 0x21=0x09 and 0x22=0x16. Write ptr 0x21, repeated START, 0x76/R, master ACK then NACK, STOP: bytes read are 0x09 then 0x16; SDA is released after the NACK.
- Reset_n low during the data ACK slot: SDA_oe=0 in the same cycle; no Wr_stb; the next full transfer succeeds.
- With IIC_GLITCH_FILTER_EN and FILTER_CYCLES=4: a 2-cycle SDA low pulse while SCL is high produces no START (Busy stays 0). A 6-cycle pulse produces a START.
